// File: rtl/roi_serial_host.sv
// Host driver for the three-wire serial ROI harness (di / stb / do).
// Shifts vectors in MSB first, strobes, and reads back the previous frame's response.
module roi_serial_host #(
    parameter int N     = 256,
    parameter int CNT_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vec_valid,
    output logic         vec_ready,
    input  logic [N-1:0] vec_data,
    output logic         resp_valid,
    output logic [N-1:0] resp_data,
    output logic         busy,
    output logic         ser_di,
    output logic         ser_stb,
    input  logic         ser_do
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] j;
    logic [N-1:0]     payload;
    logic [N-1:0]     sh;
    logic [N-1:0]     cap;
    logic             rd;
    logic             rep;
    logic             ro;
    logic             din_vld;
    logic             din_done;
    logic             accept;
    logic             last;
    logic             rd_next;

    assign vec_ready = (state == IDLE) || (state == STROBE);
    assign busy      = (state != IDLE);
    assign accept    = vec_valid && vec_ready;
    assign last      = (j == CNT_W'(N - 1));
    assign rd_next   = din_vld && !din_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = SHIFT;
            end
            SHIFT: begin
                if (last) state_nx = ro ? IDLE : STROBE;
            end
            STROBE: begin
                state_nx = SHIFT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ser_di     <= 1'b0;
            ser_stb    <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            din_vld    <= 1'b0;
            din_done   <= 1'b0;
            j          <= '0;
            rd         <= 1'b0;
            rep        <= 1'b0;
            ro         <= 1'b0;
            payload    <= '0;
            sh         <= '0;
            cap        <= '0;
        end else begin
            resp_valid <= 1'b0;
            ser_stb    <= 1'b0;
            ser_di     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        payload <= vec_data;
                        ser_di  <= vec_data[N-1];
                        sh      <= {vec_data[N-2:0], 1'b0};
                        j       <= '0;
                        rd      <= 1'b0;
                        rep     <= 1'b0;
                        ro      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (rd) cap <= {cap[N-2:0], ser_do};
                    if (last) begin
                        j <= '0;
                        if (rd) begin
                            resp_data  <= {cap[N-2:0], ser_do};
                            resp_valid <= 1'b1;
                        end
                        ser_stb <= !ro;
                    end else begin
                        j      <= j + CNT_W'(1);
                        ser_di <= sh[N-1];
                        sh     <= sh << 1;
                    end
                end
                STROBE: begin
                    // the frame just loaded is a repeat iff its response is already owed
                    rd       <= rd_next;
                    din_vld  <= 1'b1;
                    din_done <= rep;
                    j        <= '0;
                    if (accept) begin
                        payload <= vec_data;
                        ser_di  <= vec_data[N-1];
                        sh      <= {vec_data[N-2:0], 1'b0};
                        rep     <= 1'b0;
                        ro      <= 1'b0;
                    end else begin
                        // repeat frame if the new din is unread, else read-only frame
                        ser_di <= payload[N-1];
                        sh     <= {payload[N-2:0], 1'b0};
                        rep    <= 1'b1;
                        ro     <= rep;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_roi_serial_host.sv
// Bench for roi_serial_host with an inverting harness model (dout = ~din).
// Directed timing tables, corner sequences and a randomized scoreboard run.
module tb_roi_serial_host;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vec_valid = 1'b0;
    logic [N-1:0] vec_data = '0;
    logic         vec_ready;
    logic         resp_valid;
    logic [N-1:0] resp_data;
    logic         busy;
    logic         ser_di;
    logic         ser_stb;
    logic         ser_do;

    roi_serial_host #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .busy      (busy),
        .ser_di    (ser_di),
        .ser_stb   (ser_stb),
        .ser_do    (ser_do)
    );

    always #5 clk = ~clk;

    // harness model, arbitrary power-up contents
    logic [N-1:0] h_shr = 8'h3A;
    logic [N-1:0] h_din = 8'hC5;
    logic [N-1:0] h_out = 8'h96;

    always @(posedge clk) begin
        h_shr <= {h_shr[N-2:0], ser_di};
        if (ser_stb) begin
            h_din <= h_shr;
            h_out <= ~h_din;
        end else begin
            h_out <= {h_out[N-2:0], 1'b0};
        end
    end
    assign ser_do = h_out[N-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    // scoreboard: every accepted vector owes exactly one ~vector, in order
    logic [N-1:0] sbq[$];
    logic [N-1:0] rlog[$];
    int           rcyc[$];
    int           acyc[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (resp_valid) begin
                rlog.push_back(resp_data);
                rcyc.push_back(cyc);
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_spurious got %0h exp none", resp_data);
                end else begin
                    logic [N-1:0] e;
                    e = sbq.pop_front();
                    if (resp_data !== e) begin
                        errors++;
                        $display("FAIL sb_data got %0h exp %0h", resp_data, e);
                    end
                end
            end
            if (vec_valid && vec_ready) begin
                sbq.push_back(~vec_data);
                acyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [N-1:0] v);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        vec_valid = 1'b1;
        vec_data  = v;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = vec_ready;
            n++;
            @(posedge clk);
            #1;
        end
        vec_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // isolated-vector observations
    int           i_stb[$];
    logic [N-1:0] i_di;
    logic [N-1:0] i_din10;
    int           i_rk;
    logic [N-1:0] i_rd;
    logic         i_busy27;
    logic         i_rdy27;
    logic         i_rdy0;

    task automatic run_iso(input logic [N-1:0] v);
        i_stb.delete();
        i_di = '0;
        i_rk = -1;
        i_rd = '0;
        @(posedge clk);
        #1;
        vec_valid = 1'b1;
        vec_data  = v;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) i_rdy0 = vec_ready;
            if (ser_stb) i_stb.push_back(k);
            if (k >= 1 && k <= N) i_di = {i_di[N-2:0], ser_di};
            if (k == N + 2) i_din10 = h_din;
            if (resp_valid && i_rk < 0) begin
                i_rk = k;
                i_rd = resp_data;
            end
            if (k == 3 * N + 3) begin
                i_busy27 = busy;
                i_rdy27  = vec_ready;
            end
            if (k == 0) begin
                @(posedge clk);
                #1;
                vec_valid = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] vec;
        logic [N-1:0] resp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] vals[3];
        int           acc[3];
        int           s[$];
        int           idx;
        int           t0;
        logic         rdy_bad;

        tbl[0] = '{8'hA5, 8'h5A};
        tbl[1] = '{8'h80, 8'h7F};
        tbl[2] = '{8'h00, 8'hFF};
        tbl[3] = '{8'hFF, 8'h00};
        tbl[4] = '{8'h3C, 8'hC3};
        tbl[5] = '{8'h01, 8'hFE};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_stb", ser_stb, 0);
        chk("rst_di", ser_di, 0);
        chk("rst_rv", resp_valid, 0);
        chk("rst_rd", resp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", vec_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // isolated vectors: timing, serialization, load, response
        foreach (tbl[i]) begin
            run_iso(tbl[i].vec);
            chk("iso_ready0", i_rdy0, 1);
            chk("iso_nstb", i_stb.size(), 2);
            chk("iso_stb0", i_stb.size() > 0 ? i_stb[0] : -1, N + 1);
            chk("iso_stb1", i_stb.size() > 1 ? i_stb[1] : -1, 2 * N + 2);
            chk("iso_di", i_di, tbl[i].vec);
            chk("iso_din", i_din10, tbl[i].vec);
            chk("iso_rcyc", i_rk, 3 * N + 3);
            chk("iso_resp", i_rd, tbl[i].resp);
            chk("iso_busy27", i_busy27, 0);
            chk("iso_rdy27", i_rdy27, 1);
        end

        // back-to-back 01, 02, 03 accepted at each STROBE
        rlog.delete();
        rcyc.delete();
        vals[0] = 8'h01;
        vals[1] = 8'h02;
        vals[2] = 8'h03;
        acc[0] = -1;
        acc[1] = -1;
        acc[2] = -1;
        idx = 0;
        @(posedge clk);
        #1;
        t0 = cyc;
        vec_valid = 1'b1;
        vec_data  = vals[0];
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ser_stb) s.push_back(k);
            if (idx < 3 && vec_ready) begin
                acc[idx] = k;
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 3) vec_data = vals[idx];
            else vec_valid = 1'b0;
        end
        chk("b2b_acc1", acc[1], N + 1);
        chk("b2b_acc2", acc[2], 2 * N + 2);
        chk("b2b_nstb", s.size(), 4);
        chk("b2b_stb3", s.size() > 3 ? s[3] : -1, 4 * N + 4);
        chk("b2b_nresp", rlog.size(), 3);
        if (rlog.size() == 3) begin
            chk("b2b_r0", rlog[0], 8'hFE);
            chk("b2b_r1", rlog[1], 8'hFD);
            chk("b2b_r2", rlog[2], 8'hFC);
            chk("b2b_c0", rcyc[0] - t0, 3 * N + 3);
            chk("b2b_c2", rcyc[2] - t0, 5 * N + 5);
        end
        wait_idle();

        // idle gap between vectors must not duplicate a response
        rlog.delete();
        @(posedge clk);
        #1;
        send(8'h11);
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        send(8'h22);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("gap_nresp", rlog.size(), 2);
        if (rlog.size() == 2) begin
            chk("gap_r0", rlog[0], 8'hEE);
            chk("gap_r1", rlog[1], 8'hDD);
        end

        // reset in the middle of a shift
        rlog.delete();
        @(posedge clk);
        #1;
        send(8'h55);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_stb", ser_stb, 0);
        chk("mrst_rv", resp_valid, 0);
        repeat (40) @(negedge clk);
        chk("mrst_nresp", rlog.size(), 0);
        @(posedge clk);
        #1;
        send(8'h3C);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("mrst_nresp2", rlog.size(), 1);
        if (rlog.size() == 1) chk("mrst_r0", rlog[0], 8'hC3);

        // vector held during SHIFT waits for STROBE
        rlog.delete();
        acyc.delete();
        @(posedge clk);
        #1;
        send(8'h10);
        t0 = cyc - 1;
        @(posedge clk);
        #1;
        vec_valid = 1'b1;
        vec_data  = 8'h77;
        rdy_bad = 1'b0;
        for (int k = 2; k <= N; k++) begin
            @(negedge clk);
            rdy_bad = rdy_bad | vec_ready;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("hold_rdy_shift", rdy_bad, 0);
        chk("hold_rdy_stb", vec_ready, 1);
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        chk("hold_nacc", acyc.size(), 2);
        if (acyc.size() == 2) chk("hold_acyc", acyc[1] - t0, N + 1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("hold_nresp", rlog.size(), 2);
        if (rlog.size() == 2) begin
            chk("hold_r0", rlog[0], 8'hEF);
            chk("hold_r1", rlog[1], 8'h88);
        end

        // randomized traffic against the scoreboard
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) begin
            int g;
            g = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 25);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            send(N'($urandom));
        end
        wait_idle();
        repeat (5) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
